uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmit framing controller that sits directly upstream of the transmit parallel-in/serial-out shift register. It accepts a byte over a valid/ready handshake and loads it into the shift register. It paces the shift register at the baud rate and drives the serial `tx` line with start bit, eight data bits LSB first, optional parity and stop bit(s). It owns the baud counter, bit counter and frame FSM; the shift register holds the data bits only.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `STOP_BITS`, 1, number of stop bits; 1 or 2.
- `clk`  in  1  system clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `tx_data`  in  8  byte to send; sampled on the accept edge.
- `tx_valid`  in  1  byte available.
- `tx_ready`  out  1  controller can accept a byte (high only in IDLE).
- `tx_busy`  out  1  frame in progress (any state other than IDLE).
- `piso_load`  out  1  load strobe to shift register.
- `piso_shift`  out  1  shift-right strobe to shift register.
- `piso_data`  out  8  parallel data to shift register (equals `tx_data`).
- `piso_bit`  in  1  shift register LSB (current data bit).
- `tx`  out  1  serial line, idle high.

## Operation
- States: IDLE, START, DATA, PARITY (present only with macro), STOP.
- Reset values: state IDLE, baud counter 0, bit counter 0, parity reg 0; `tx`=1, `tx_ready`=1, `tx_busy`=0, `piso_load`=0, `piso_shift`=0.
- Accept: `tx_valid && tx_ready` at a rising edge.
  - `piso_load` = `tx_valid && tx_ready` combinationally, so the shift register captures `piso_data` on the accept edge.
  - The same edge moves the state to START and clears both counters.
- `tx` decode, from registered state only:
  - IDLE/STOP → 1.
  - START → 0.
  - DATA → `piso_bit`.
  - PARITY → parity reg.
- Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state, width $clog2(CLKS_PER_BIT). "bit_end" = counter == CLKS_PER_BIT-1; the counter wraps to 0 on bit_end.
- START: on bit_end → DATA, bit counter 0.
- DATA:
  - `piso_shift` = 1 for exactly the bit_end cycle of each data bit, including bit 7.
  - On bit_end, the bit counter increments (3-bit).
  - On bit_end with bit counter == 7 → PARITY if enabled, else STOP.
- STOP:
  - Lasts STOP_BITS × CLKS_PER_BIT cycles. The bit counter counts stop bits.
  - On the final bit_end → IDLE.
- `tx_valid` while not in IDLE is ignored; no byte is lost or queued, and the source holds it.
- Reset mid-frame: all state returns to reset values immediately (async); `tx` goes high without completing the frame.

## Timing
- Accept edge E0. The start bit occupies cycles E0+1 .. E0+CLKS_PER_BIT. Data bit *n* begins at E0+1+(n+1)·CLKS_PER_BIT.
- Frame length from E0+1: (1+8+P+STOP_BITS)·CLKS_PER_BIT cycles, where P = 1 with parity, else 0.
- `tx_ready` rises the cycle after the last stop-bit cycle.
- Back-to-back operation with `tx_valid` held high gives exactly one idle-high clock between frames.
- `piso_load` and `piso_shift` are never high in the same cycle.
- `tx` has zero added latency relative to state: it is a combinational decode of registers.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state exists.
  - The parity reg is loaded with ^`tx_data` (even parity) on the accept edge.
  - One parity bit is sent between bit 7 and stop.
- Undefined: there is no PARITY state and no parity reg; DATA goes directly to STOP; the frame is 8N1/8N2.

## Test plan
- Reset: hold `reset_n`=0 → `tx`=1, `tx_ready`=1, `tx_busy`=0, no strobes. Release with `tx_valid`=0 for 50 cycles → outputs unchanged.
- Single byte 0xA5, CLKS_PER_BIT=4, no parity, STOP_BITS=1:
  - `piso_load` pulses once at accept.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - 8 `piso_shift` pulses 4 cycles apart.
  - `tx_ready` high at cycle 41 after accept.
- Parity enabled, byte 0x07 → parity bit 1. Byte 0x03 → parity bit 0. Frame is 44 cycles at CLKS_PER_BIT=4.
- Back-to-back 0x55 then 0xFF with `tx_valid` held: exactly one idle-high cycle between frames. The second frame's start bit begins 2 cycles after the first frame's last stop cycle ends… precisely, the cycle after the idle cycle.
- `tx_valid` toggled during DATA of byte 0x3C: the second byte is not loaded, and no extra `piso_load`. The frame is unchanged.
- Assert `reset_n`=0 during data bit 3: `tx`=1 asynchronously, state IDLE. After release, a new byte 0x81 transmits correctly.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit framing controller: paces an external PISO shift register and drives tx.
// Define UART_TX_PARITY_EN to append an even-parity bit between data bit 7 and the stop bit(s).
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       piso_load,
    output logic       piso_shift,
    output logic [7:0] piso_data,
    input  logic       piso_bit,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic          bit_end;
    logic          accept;
`ifdef UART_TX_PARITY_EN
    logic          parity;
`endif

    assign tx_ready   = (state == S_IDLE);
    assign tx_busy    = (state != S_IDLE);
    assign accept     = tx_valid && tx_ready;
    assign piso_load  = accept;
    assign piso_data  = tx_data;
    assign bit_end    = (state != S_IDLE) && (baud_cnt == BAUD_LAST);
    // bit_end never coincides with IDLE, so load and shift are mutually exclusive
    assign piso_shift = (state == S_DATA) && bit_end;

    always_comb begin
        tx = 1'b1;
        case (state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = piso_bit;
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx = parity;
`endif
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            if (state == S_IDLE)
                baud_cnt <= '0;
            else
                baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state   <= S_START;
                        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        parity  <= ^tx_data;
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    // bit_cnt wraps 7 -> 0, so it enters the next state already cleared
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state   <= S_STOP;
                        bit_cnt <= '0;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            state   <= S_IDLE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frames are predicted bit-by-bit from the byte value and compared per clock.
module tb_uart_tx_ctrl;

    localparam int C  = 4;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 1 + 8 + P + SB;
    localparam int FRAME = NBITS * C;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, piso_load, piso_shift, piso_bit, tx;
    logic [7:0] piso_data;
    logic [7:0] sr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(C), .STOP_BITS(SB)) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .piso_load(piso_load),
        .piso_shift(piso_shift), .piso_data(piso_data), .piso_bit(piso_bit), .tx(tx)
    );

    // external shift register the controller drives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        sr <= 8'h00;
        else if (piso_load)  sr <= piso_data;
        else if (piso_shift) sr <= {1'b0, sr[7:1]};
    end
    assign piso_bit = sr[0];

    // Called at a negedge; returns at the negedge of the first idle cycle after the frame.
    task automatic frame(input logic [7:0] d, input bit keep, input bit noise);
        logic [15:0] bits;
        logic exp_tx, exp_shift, exp_ready, exp_load;
        int b;
        bits = '1;
        bits[0] = 1'b0;
        for (int n = 0; n < 8; n++) bits[1+n] = d[n];
        if (P == 1) bits[9] = ^d;
        tx_data  = d;
        tx_valid = 1'b1;
        #1;
        vectors++;
        if (piso_load !== 1'b1 || tx_ready !== 1'b1 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL accept d=%02h: load=%b ready=%b tx=%b, want 1 1 1", d, piso_load, tx_ready, tx);
        end
        @(posedge clk);
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clk);
            b         = (k - 1) / C;
            exp_tx    = (k <= FRAME) ? bits[b] : 1'b1;
            exp_shift = (k <= FRAME) && (b >= 1) && (b <= 8) && (k % C == 0);
            exp_ready = (k == FRAME + 1);
            exp_load  = exp_ready && keep;
            vectors++;
            if (tx !== exp_tx) begin
                miscompares++;
                $display("FAIL tx d=%02h cyc=%0d: got %b want %b", d, k, tx, exp_tx);
            end
            vectors++;
            if (piso_shift !== exp_shift) begin
                miscompares++;
                $display("FAIL shift d=%02h cyc=%0d: got %b want %b", d, k, piso_shift, exp_shift);
            end
            vectors++;
            if (piso_load !== exp_load) begin
                miscompares++;
                $display("FAIL load d=%02h cyc=%0d: got %b want %b", d, k, piso_load, exp_load);
            end
            vectors++;
            if (tx_ready !== exp_ready || tx_busy !== !exp_ready) begin
                miscompares++;
                $display("FAIL ready/busy d=%02h cyc=%0d: got %b/%b want %b/%b",
                         d, k, tx_ready, tx_busy, exp_ready, !exp_ready);
            end
            if (k < FRAME) begin
                tx_valid = keep ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
                if (noise) tx_data = 8'($urandom);
            end else if (k == FRAME) begin
                tx_valid = keep;
            end
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || piso_load !== 1'b0 || piso_shift !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: tx/rdy/busy/ld/sh=%b%b%b%b%b want 11000",
                     tx, tx_ready, tx_busy, piso_load, piso_shift);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || piso_load !== 1'b0 || piso_shift !== 1'b0) begin
                miscompares++;
                $display("FAIL idle cyc=%0d: tx/rdy/busy/ld/sh=%b%b%b%b%b want 11000",
                         i, tx, tx_ready, tx_busy, piso_load, piso_shift);
            end
        end
    endtask

    task automatic test_single();
        frame(8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_parity();
        frame(8'h07, 1'b0, 1'b0);
        frame(8'h03, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        frame(8'h55, 1'b1, 1'b0);
        frame(8'hFF, 1'b0, 1'b0);
    endtask

    task automatic test_valid_noise();
        frame(8'h3C, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (4 * C + 1) @(negedge clk);
        vectors++;
        if (tx_busy !== 1'b1 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_frame_bit3: busy=%b tx=%b want 1 1", tx_busy, tx);
        end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || piso_shift !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: tx/rdy/busy/sh=%b%b%b%b want 1100", tx, tx_ready, tx_busy, piso_shift);
        end
        @(negedge clk);
        reset_n = 1'b1;
        frame(8'h81, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        bit keep;
        for (int i = 0; i < 8; i++) begin
            keep = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            frame(8'($urandom), keep, 1'($urandom_range(0, 1)));
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_valid_noise();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
